// File: rtl/lsf_engine_scheduler.sv
// Round-robin scheduler sharing one legendre engine among N_ST stations.
// Grants a station, muxes its ROI/hit FIFOs to the engine, then waits for the result.
module lsf_engine_scheduler #(
    parameter int N_ST   = 3,
    parameter int HIT_W  = 32,
    parameter int ROI_W  = 32,
    parameter int TMO_W  = 12,
    parameter int SF_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              acc_count,
    input  logic [TMO_W-1:0]        tmo_limit,
    input  logic [N_ST*ROI_W-1:0]   st_roi_data,
    input  logic [N_ST-1:0]         st_roi_empty,
    output logic [N_ST-1:0]         st_roi_re,
    input  logic [N_ST*HIT_W-1:0]   st_hit_data,
    input  logic [N_ST-1:0]         st_hit_empty,
    output logic [N_ST-1:0]         st_hit_re,
    output logic [ROI_W-1:0]        eng_roi,
    output logic                    eng_roi_empty,
    input  logic                    eng_roi_re,
    output logic [HIT_W-1:0]        eng_hit,
    output logic                    eng_hit_empty,
    input  logic                    eng_hit_re,
    input  logic [SF_LEN-1:0]       eng_sf,
    input  logic                    eng_sf_vld,
    output logic [SF_LEN-1:0]       out_sf,
    output logic                    out_vld,
    output logic [1:0]              out_station,
    output logic                    tmo_err,
    output logic                    busy
);

    localparam int GW = (N_ST > 1) ? $clog2(N_ST) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROI,
        S_HITS,
        S_WAIT
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   rr_ptr;
    logic [9:0]      acc_q;
    logic [9:0]      win_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W:0]  tmo_nxt;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   pick_nxt;
    logic            found;

    // First non-empty ROI FIFO at or after rr_ptr, wrapping at N_ST
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_ST; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N_ST) idx = idx - N_ST;
            if (!found && !st_roi_empty[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        pick_nxt = (pick == GW'(N_ST - 1)) ? '0 : pick + 1'b1;
    end

    assign tmo_nxt = {1'b0, tmo_cnt} + 1'b1;
    assign busy    = (state != S_IDLE);

    // Engine-side muxing; FIFO reads only reach the granted station
    always_comb begin
        eng_roi       = st_roi_data[grant*ROI_W +: ROI_W];
        eng_hit       = st_hit_data[grant*HIT_W +: HIT_W];
        eng_roi_empty = 1'b1;
        eng_hit_empty = 1'b1;
        st_roi_re     = '0;
        st_hit_re     = '0;
        if (state == S_ROI) begin
            eng_roi_empty    = st_roi_empty[grant];
            st_roi_re[grant] = eng_roi_re;
        end
        if (state == S_HITS) begin
            eng_hit_empty    = st_hit_empty[grant];
            st_hit_re[grant] = eng_hit_re & ~st_hit_empty[grant];
        end
    end

    // Event FSM: grant, ROI handoff, hit window, result/timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            acc_q       <= '0;
            win_cnt     <= '0;
            tmo_cnt     <= '0;
            out_sf      <= '0;
            out_station <= '0;
            out_vld     <= 1'b0;
            tmo_err     <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            tmo_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        grant  <= pick;
                        rr_ptr <= pick_nxt;
                        acc_q  <= acc_count;
                        state  <= S_ROI;
                    end
                end
                S_ROI: begin
                    if (eng_roi_re && !st_roi_empty[grant]) begin
                        win_cnt <= acc_q;
                        state   <= S_HITS;
                    end
                end
                S_HITS: begin
                    if (win_cnt == '0) begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT;
                    end else begin
                        win_cnt <= win_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (eng_sf_vld) begin
                        out_sf      <= eng_sf;
                        out_station <= 2'(grant);
                        out_vld     <= 1'b1;
                        state       <= S_IDLE;
                    end else if (tmo_nxt >= {1'b0, tmo_limit}) begin
                        tmo_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_nxt[TMO_W-1:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsf_engine_scheduler.sv
// Scoreboard bench for lsf_engine_scheduler: directed events, queued results,
// negedge monitor comparing out_vld/tmo_err strobes with the expected cycle.
module tb_lsf_engine_scheduler;

    localparam int N_ST   = 3;
    localparam int HIT_W  = 32;
    localparam int ROI_W  = 32;
    localparam int TMO_W  = 12;
    localparam int SF_LEN = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [9:0]            acc_count;
    logic [TMO_W-1:0]      tmo_limit;
    logic [N_ST*ROI_W-1:0] st_roi_data;
    logic [N_ST-1:0]       st_roi_empty;
    logic [N_ST-1:0]       st_roi_re;
    logic [N_ST*HIT_W-1:0] st_hit_data;
    logic [N_ST-1:0]       st_hit_empty;
    logic [N_ST-1:0]       st_hit_re;
    logic [ROI_W-1:0]      eng_roi;
    logic                  eng_roi_empty;
    logic                  eng_roi_re;
    logic [HIT_W-1:0]      eng_hit;
    logic                  eng_hit_empty;
    logic                  eng_hit_re;
    logic [SF_LEN-1:0]     eng_sf;
    logic                  eng_sf_vld;
    logic [SF_LEN-1:0]     out_sf;
    logic                  out_vld;
    logic [1:0]            out_station;
    logic                  tmo_err;
    logic                  busy;

    typedef struct {
        bit                tmo;
        int                st;
        logic [SF_LEN-1:0] sf;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    lsf_engine_scheduler #(
        .N_ST(N_ST), .HIT_W(HIT_W), .ROI_W(ROI_W),
        .TMO_W(TMO_W), .SF_LEN(SF_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .acc_count(acc_count), .tmo_limit(tmo_limit),
        .st_roi_data(st_roi_data), .st_roi_empty(st_roi_empty),
        .st_roi_re(st_roi_re),
        .st_hit_data(st_hit_data), .st_hit_empty(st_hit_empty),
        .st_hit_re(st_hit_re),
        .eng_roi(eng_roi), .eng_roi_empty(eng_roi_empty),
        .eng_roi_re(eng_roi_re),
        .eng_hit(eng_hit), .eng_hit_empty(eng_hit_empty),
        .eng_hit_re(eng_hit_re),
        .eng_sf(eng_sf), .eng_sf_vld(eng_sf_vld),
        .out_sf(out_sf), .out_vld(out_vld),
        .out_station(out_station), .tmo_err(tmo_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [ROI_W-1:0] roi_of(input int i);
        return ROI_W'(32'hA0A0_0000 + i);
    endfunction

    function automatic logic [HIT_W-1:0] hit_of(input int i);
        return HIT_W'(32'h5151_0000 + i);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (out_vld || tmo_err) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: vld=%0b tmo=%0b st=%0d sf=%0h cyc=%0d",
                         out_vld, tmo_err, out_station, out_sf, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (tmo_err !== e.tmo || out_vld !== !e.tmo || cyc != e.due ||
                    (!e.tmo && (int'(out_station) != e.st || out_sf !== e.sf))) begin
                    bad++;
                    $display("FAIL result: got vld=%0b tmo=%0b st=%0d sf=%0h cyc=%0d want tmo=%0b st=%0d sf=%0h cyc=%0d",
                             out_vld, tmo_err, out_station, out_sf, cyc,
                             e.tmo, e.st, e.sf, e.due);
                end
            end
        end
    end

    // mode 0: result d cycles into WAIT; 1: timeout; 2: result on timeout cycle
    task automatic run_event(input int st, input int acc, input int mode,
                             input int d, input logic [SF_LEN-1:0] sf,
                             input bit pop, input bit hempty);
        int   t;
        int   w;
        int   lim;
        exp_t e;
        acc_count        = 10'(acc);
        st_hit_empty[st] = hempty;
        lim              = int'(tmo_limit);
        t                = 0;
        @(negedge clk);
        while (!busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("grant_seen", 64'(busy), 64'd1);
        if (!busy) return;
        chk("roi_empty", 64'(eng_roi_empty), 64'd0);
        chk("roi_data", 64'(eng_roi), 64'(roi_of(st)));
        eng_roi_re = 1'b1;
        #1;
        chk("roi_re", 64'(st_roi_re), 64'(1 << st));
        @(posedge clk);
        #1;
        eng_roi_re = 1'b0;
        if (pop) st_roi_empty[st] = 1'b1;
        eng_hit_re = 1'b1;
        for (int k = 0; k <= acc; k++) begin
            @(negedge clk);
            chk("hit_empty", 64'(eng_hit_empty), 64'(hempty));
            chk("hit_re", 64'(st_hit_re), hempty ? 64'd0 : 64'(1 << st));
            if (!hempty) chk("hit_data", 64'(eng_hit), 64'(hit_of(st)));
        end
        @(negedge clk);
        chk("wait_hit_empty", 64'(eng_hit_empty), 64'd1);
        chk("wait_hit_re", 64'(st_hit_re), 64'd0);
        eng_hit_re = 1'b0;
        w = cyc;
        if (mode == 1) begin
            e = '{tmo: 1'b1, st: st, sf: '0, due: w + lim};
            sb.push_back(e);
            repeat (lim) @(negedge clk);
        end else begin
            repeat ((mode == 2) ? lim - 1 : d) @(negedge clk);
            eng_sf     = sf;
            eng_sf_vld = 1'b1;
            e = '{tmo: 1'b0, st: st, sf: sf, due: cyc + 1};
            sb.push_back(e);
            @(negedge clk);
            eng_sf_vld = 1'b0;
        end
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int t;
        acc_count    = '0;
        tmo_limit    = 12'd100;
        st_roi_empty = '1;
        st_hit_empty = '0;
        eng_roi_re   = 1'b0;
        eng_hit_re   = 1'b0;
        eng_sf       = '0;
        eng_sf_vld   = 1'b0;
        for (int i = 0; i < N_ST; i++) begin
            st_roi_data[i*ROI_W +: ROI_W] = roi_of(i);
            st_hit_data[i*HIT_W +: HIT_W] = hit_of(i);
        end

        // Reset state, with ungated engine reads held high
        repeat (2) @(posedge clk);
        eng_roi_re = 1'b1;
        eng_hit_re = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_tmo_err", 64'(tmo_err), 64'd0);
        chk("rst_out_sf", 64'(out_sf), 64'd0);
        chk("rst_out_station", 64'(out_station), 64'd0);
        chk("rst_roi_empty", 64'(eng_roi_empty), 64'd1);
        chk("rst_hit_empty", 64'(eng_hit_empty), 64'd1);
        chk("rst_roi_re", 64'(st_roi_re), 64'd0);
        chk("rst_hit_re", 64'(st_hit_re), 64'd0);
        @(negedge clk);
        chk("idle_hit_re", 64'(st_hit_re), 64'd0);
        eng_roi_re = 1'b0;
        eng_hit_re = 1'b0;

        // Single station 1 event, acc 4, result 3 cycles into WAIT
        st_roi_empty = 3'b101;
        run_event(1, 4, 0, 3, 32'hCAFE_0001, 1'b1, 1'b0);

        // Reset returns rr_ptr to 0, then round robin over all three
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        st_roi_empty = 3'b000;
        run_event(0, 0, 0, 0, 32'h1111_0000, 1'b0, 1'b0);
        run_event(1, 2, 0, 1, 32'h2222_0001, 1'b0, 1'b0);
        run_event(2, 1, 0, 2, 32'h3333_0002, 1'b0, 1'b0);
        st_roi_empty = 3'b110;
        run_event(0, 3, 0, 1, 32'h4444_0000, 1'b1, 1'b0);

        // Timeout with no result, then the next grant still proceeds
        tmo_limit    = 12'd8;
        st_roi_empty = 3'b101;
        run_event(1, 2, 1, 0, '0, 1'b1, 1'b0);
        st_roi_empty = 3'b011;
        run_event(2, 1, 2, 0, 32'h5555_0002, 1'b1, 1'b0);

        // Granted hit FIFO empty while engine keeps reading
        tmo_limit    = 12'd100;
        st_roi_empty = 3'b110;
        run_event(0, 3, 0, 2, 32'h6666_0000, 1'b1, 1'b1);
        st_hit_empty = '0;

        // rr_ptr is 1: station 2 wins before wrapping to 0
        st_roi_empty = 3'b010;
        run_event(2, 0, 0, 0, 32'h7777_0002, 1'b1, 1'b0);
        run_event(0, 1, 0, 1, 32'h8888_0000, 1'b1, 1'b0);

        // Result valid while idle is dropped
        st_roi_empty = '1;
        eng_sf       = 32'hDEAD_BEEF;
        eng_sf_vld   = 1'b1;
        repeat (3) @(negedge clk);
        eng_sf_vld = 1'b0;
        chk("idle_sf_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        // Reset during HITS abandons the event
        acc_count    = 10'd10;
        st_roi_empty = 3'b110;
        t = 0;
        @(negedge clk);
        while (!busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("mid_grant_seen", 64'(busy), 64'd1);
        eng_roi_re = 1'b1;
        @(posedge clk);
        #1;
        eng_roi_re = 1'b0;
        eng_hit_re = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_in_hits", 64'(eng_hit_empty), 64'd0);
        st_roi_empty = '1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_out_sf", 64'(out_sf), 64'd0);
        chk("mid_out_vld", 64'(out_vld), 64'd0);
        chk("mid_tmo_err", 64'(tmo_err), 64'd0);
        chk("mid_hit_empty", 64'(eng_hit_empty), 64'd1);
        chk("mid_roi_empty", 64'(eng_roi_empty), 64'd1);
        chk("mid_hit_re", 64'(st_hit_re), 64'd0);
        eng_sf_vld = 1'b1;
        repeat (4) @(negedge clk);
        eng_sf_vld = 1'b0;
        eng_hit_re = 1'b0;
        repeat (20) @(negedge clk);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

endmodule
